doom_hps_cmd_master: RTL and testbench
======================================

Name: doom_hps_cmd_master

Overview:
- Avalon-MM host that issues commands to the doom_fpga HPS control slave, acting as the initiator for that slave's command protocol.
- Accepts one command at a time on a valid/ready port and writes its argument words to slave addresses 1..N, then the command code to address 0.
- Reads back a status word once the slave drops waitrequest, then returns that word as the response.
- Used for on-FPGA command replay/self-test in place of the HPS bridge.

Parameters:
NUM_ARGS, 3, maximum argument words per command (1..3)
STATUS_ADDR, 8'h04, slave address read to collect completion status
TIMEOUT_CYCLES, 65535, max cycles any single Avalon transfer may stall before abort

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command
cmd_code  input  32  command word (CMD_* constants)
cmd_nargs  input  2  argument count, 0..NUM_ARGS
cmd_args  input  NUM_ARGS*32  argument i at bits [32i+31:32i]
rsp_valid  output  1  one-cycle response strobe
rsp_data  output  32  status word read from STATUS_ADDR (0 on timeout)
rsp_timeout  output  1  qualifies rsp_valid: transfer aborted on timeout
busy  output  1  a command is in flight
avm_address  output  8  slave address
avm_write  output  1  write request
avm_writedata  output  32  write data
avm_read  output  1  read request
avm_readdata  input  32  read data
avm_waitrequest  input  1  slave stall

Behaviour:
- Reset (async, immediate): state IDLE; cmd_ready=1; busy, rsp_valid, rsp_timeout, avm_write, avm_read = 0; avm_address, avm_writedata, rsp_data = 0; all internal latches and counters = 0.
- Accept: in IDLE with cmd_valid=1, capture cmd_code, cmd_nargs and cmd_args on the rising edge. cmd_ready=0 and busy=1 from the next cycle.
- cmd_nargs > NUM_ARGS is clamped to NUM_ARGS.
- States: IDLE, ARG, CMD, POLL, RESP.
- IDLE -> ARG if nargs > 0, else IDLE -> CMD. Transition on the accept edge; the first Avalon request is asserted in the following cycle.
- ARG:
  - Drives avm_write=1, avm_address=idx+1, avm_writedata=args[idx], with idx starting at 0.
  - A beat completes on a cycle with avm_waitrequest=0: idx increments, or the state moves to CMD after beat nargs-1.
  - Back-to-back beats have no idle cycle between them.
- CMD: avm_write=1, avm_address=0, avm_writedata=cmd_code. On completion, go to POLL.
- POLL: avm_read=1, avm_address=STATUS_ADDR. On avm_waitrequest=0, latch avm_readdata into rsp_data and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle. Next cycle: IDLE, cmd_ready=1, busy=0.
- Minimum latency with no stalls: accept edge -> rsp_valid = nargs+3 cycles.
- Avalon rules:
  - Address, data and the command strobe are held stable while waitrequest=1.
  - avm_read and avm_write are never asserted together.
  - avm_address, avm_writedata = 0 when no strobe is asserted.
- Timeout:
  - A counter clears at the start of each transfer and increments on each cycle the transfer stalls with waitrequest=1.
  - When it reaches TIMEOUT_CYCLES, the strobe deasserts on the next edge, remaining beats are skipped, and the state goes to RESP with rsp_timeout=1 and rsp_data=0.
  - rsp_timeout=0 on normal completion and is only meaningful with rsp_valid.
- cmd_valid asserted while busy is ignored; the command is neither captured nor queued.
- Reset mid-transfer: strobes drop immediately (async) and no response is emitted.
- Counter width: clog2(TIMEOUT_CYCLES+1); saturates and never wraps.

Test Plan:
- Reset released, idle: cmd_ready=1, all strobes 0, rsp_valid never fires.
- cmd_code=CMD_V_Init, nargs=1, arg0=32'h3000_0000, no stalls:
  - write addr 1 data 3000_0000, then write addr 0 data CMD_V_Init, then read addr 04.
  - readdata=0 -> rsp_valid 4 cycles after accept, rsp_data=0, rsp_timeout=0.
- CMD_I_FinishUpdate, nargs=0; waitrequest held 1 for 40 cycles during POLL, readdata=32'h5:
  - avm_read and address stay stable throughout; rsp_data=5; busy deasserts the cycle after rsp_valid.
- nargs=3, args=11,22,33; waitrequest pulses high 1 cycle on beat 2:
  - address sequence 1,2,2,3,0,04; beat 2 data held at 22; cmd_ready=0 throughout.
- TIMEOUT_CYCLES=8, waitrequest stuck 1 during CMD:
  - avm_write drops after 8 stall cycles, no POLL read issued; rsp_valid=1, rsp_timeout=1, rsp_data=0.
- Reset asserted mid-ARG, then cmd_valid pulsed while busy on a fresh command:
  - strobes 0 immediately, no rsp_valid; the second cmd_valid while busy leaves exactly one response.

Source files
------------

// File: rtl/doom_hps_cmd_master.sv
// ---------------------------------------------------------------------------
// doom_hps_cmd_master
//
// Avalon-MM host that drives the doom_fpga HPS control slave in place of the
// HPS bridge, so commands can be replayed or self-tested on the FPGA.
//
// A command accepted on the valid/ready port is executed as follows:
//   1. Each argument word i is written to slave address i+1.
//   2. The command code is written to address 0.
//   3. STATUS_ADDR is read.
//   4. The word read back is returned as a one-cycle response.
// Any single transfer that stalls for TIMEOUT_CYCLES cycles is abandoned.
// The response then carries rsp_timeout=1 and rsp_data=0.
//
// Ports
//   i_clk, i_reset      : clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready, i_cmd_code, i_cmd_nargs, i_cmd_args
//                       : command request port
//   o_rsp_valid, o_rsp_data, o_rsp_timeout
//                       : response strobe, status word and timeout flag
//   o_busy              : a command is in flight
//   o_avm_*/i_avm_*     : Avalon-MM host interface
// ---------------------------------------------------------------------------
module doom_hps_cmd_master #(
    parameter int unsigned NUM_ARGS       = 3,
    parameter logic [7:0]  STATUS_ADDR    = 8'h04,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [31:0]              i_cmd_code,
    input  logic [1:0]               i_cmd_nargs,
    input  logic [NUM_ARGS*32-1:0]   i_cmd_args,
    output logic                     o_rsp_valid,
    output logic [31:0]              o_rsp_data,
    output logic                     o_rsp_timeout,
    output logic                     o_busy,
    output logic [7:0]               o_avm_address,
    output logic                     o_avm_write,
    output logic [31:0]              o_avm_writedata,
    output logic                     o_avm_read,
    input  logic [31:0]              i_avm_readdata,
    input  logic                     i_avm_waitrequest
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]       NARGS_MAX = 2'(NUM_ARGS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARG  = 3'd1,
        S_CMD  = 3'd2,
        S_POLL = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_code;
    logic [1:0]             r_nargs;
    logic [NUM_ARGS*32-1:0] r_args;
    logic [1:0]             r_idx;
    logic [CNT_W-1:0]       r_to_cnt;
    logic                   r_cmd_ready;
    logic                   r_busy;
    logic                   r_rsp_valid;
    logic                   r_rsp_timeout;
    logic [31:0]            r_rsp_data;
    logic [7:0]             r_avm_address;
    logic                   r_avm_write;
    logic [31:0]            r_avm_writedata;
    logic                   r_avm_read;

    logic [1:0]             w_nargs;
    logic [1:0]             w_next_idx;
    logic                   w_last_beat;
    logic                   w_expired;

    // Select argument word idx from a packed argument vector.
    function automatic logic [31:0] arg_word(input logic [NUM_ARGS*32-1:0] args,
                                             input logic [1:0] idx);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (idx == 2'(i)) begin
                w = args[32*i +: 32];
            end
        end
        return w;
    endfunction

    // Out-of-range argument counts are clamped rather than rejected.
    assign w_nargs     = (i_cmd_nargs > NARGS_MAX) ? NARGS_MAX : i_cmd_nargs;
    assign w_next_idx  = r_idx + 2'd1;
    assign w_last_beat = (r_idx == (r_nargs - 2'd1));
    // Current stall cycle is the TIMEOUT_CYCLES-th one: abort at this edge.
    assign w_expired   = (r_to_cnt == CNT_LAST);

    // Command sequencer: state, captured command, Avalon strobes and response.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_code          <= 32'd0;
            r_nargs         <= 2'd0;
            r_args          <= '0;
            r_idx           <= 2'd0;
            r_to_cnt        <= '0;
            r_cmd_ready     <= 1'b1;
            r_busy          <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_timeout   <= 1'b0;
            r_rsp_data      <= 32'd0;
            r_avm_address   <= 8'd0;
            r_avm_write     <= 1'b0;
            r_avm_writedata <= 32'd0;
            r_avm_read      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_code      <= i_cmd_code;
                        r_nargs     <= w_nargs;
                        r_args      <= i_cmd_args;
                        r_idx       <= 2'd0;
                        r_to_cnt    <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_avm_write <= 1'b1;
                        if (w_nargs != 2'd0) begin
                            r_state         <= S_ARG;
                            r_avm_address   <= 8'd1;
                            r_avm_writedata <= arg_word(i_cmd_args, 2'd0);
                        end else begin
                            r_state         <= S_CMD;
                            r_avm_address   <= 8'd0;
                            r_avm_writedata <= i_cmd_code;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_ARG, S_CMD, S_POLL: begin
                    if (i_avm_waitrequest) begin
                        if (w_expired) begin
                            // Abandon the command: skip all remaining beats.
                            r_state         <= S_RESP;
                            r_avm_write     <= 1'b0;
                            r_avm_read      <= 1'b0;
                            r_avm_address   <= 8'd0;
                            r_avm_writedata <= 32'd0;
                            r_rsp_valid     <= 1'b1;
                            r_rsp_timeout   <= 1'b1;
                            r_rsp_data      <= 32'd0;
                        end else if (r_to_cnt != CNT_MAX) begin
                            r_to_cnt <= r_to_cnt + CNT_W'(1);
                        end else begin
                            r_to_cnt <= r_to_cnt;
                        end
                    end else begin
                        // Transfer completes; the next one starts with a fresh count.
                        r_to_cnt <= '0;
                        if (r_state == S_ARG) begin
                            if (w_last_beat) begin
                                r_state         <= S_CMD;
                                r_avm_address   <= 8'd0;
                                r_avm_writedata <= r_code;
                            end else begin
                                r_idx           <= w_next_idx;
                                r_avm_address   <= 8'(w_next_idx) + 8'd1;
                                r_avm_writedata <= arg_word(r_args, w_next_idx);
                            end
                        end else if (r_state == S_CMD) begin
                            r_state         <= S_POLL;
                            r_avm_write     <= 1'b0;
                            r_avm_read      <= 1'b1;
                            r_avm_address   <= STATUS_ADDR;
                            r_avm_writedata <= 32'd0;
                        end else begin
                            r_state       <= S_RESP;
                            r_avm_read    <= 1'b0;
                            r_avm_address <= 8'd0;
                            r_rsp_data    <= i_avm_readdata;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_timeout <= 1'b0;
                        end
                    end
                end

                S_RESP: begin
                    r_state       <= S_IDLE;
                    r_rsp_valid   <= 1'b0;
                    r_rsp_timeout <= 1'b0;
                    r_cmd_ready   <= 1'b1;
                    r_busy        <= 1'b0;
                end

                default: begin
                    r_state         <= S_IDLE;
                    r_rsp_valid     <= 1'b0;
                    r_rsp_timeout   <= 1'b0;
                    r_cmd_ready     <= 1'b1;
                    r_busy          <= 1'b0;
                    r_avm_write     <= 1'b0;
                    r_avm_read      <= 1'b0;
                    r_avm_address   <= 8'd0;
                    r_avm_writedata <= 32'd0;
                end
            endcase
        end
    end

    assign o_cmd_ready     = r_cmd_ready;
    assign o_busy          = r_busy;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_timeout   = r_rsp_timeout;
    assign o_rsp_data      = r_rsp_data;
    assign o_avm_address   = r_avm_address;
    assign o_avm_write     = r_avm_write;
    assign o_avm_writedata = r_avm_writedata;
    assign o_avm_read      = r_avm_read;

endmodule

// File: tb/tb_doom_hps_cmd_master.sv
// Scoreboard bench for doom_hps_cmd_master.
//
// The stimulus side does three things for every command:
//   - computes the Avalon transfers the slave should see;
//   - computes the response the requester should get, and its latency;
//   - chooses the slave's stall length for each transfer.
// A negedge slave/monitor process serves the bus from those stall choices.
// It pops and compares expectations whenever a transfer completes or
// rsp_valid fires.
module tb_doom_hps_cmd_master;

    localparam int NA = 3;
    localparam int TO = 8;
    localparam logic [7:0] SA = 8'h04;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_code;
    logic [1:0]    cmd_nargs;
    logic [NA*32-1:0] cmd_args;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic          rsp_timeout;
    logic          busy;
    logic [7:0]    avm_address;
    logic          avm_write;
    logic [31:0]   avm_writedata;
    logic          avm_read;
    logic [31:0]   avm_readdata;
    logic          avm_waitrequest;

    doom_hps_cmd_master #(
        .NUM_ARGS(NA), .STATUS_ADDR(SA), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_code(cmd_code), .i_cmd_nargs(cmd_nargs), .i_cmd_args(cmd_args),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_timeout(rsp_timeout),
        .o_busy(busy),
        .o_avm_address(avm_address), .o_avm_write(avm_write),
        .o_avm_writedata(avm_writedata), .o_avm_read(avm_read),
        .i_avm_readdata(avm_readdata), .i_avm_waitrequest(avm_waitrequest)
    );

    typedef struct {
        bit          rd;
        logic [7:0]  addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic [31:0] data;
        bit          to;
        int          acc;
        int          lat;
    } rsp_t;

    xfer_t       exp_x[$];
    rsp_t        exp_r[$];
    int          stall_q[$];
    logic [31:0] rd_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model and monitor state.
    bit          in_x = 1'b0;
    int          s_len = 0;
    int          s_cnt = 0;
    bit          h_rd;
    logic [7:0]  h_addr;
    logic [31:0] h_data;

    always @(negedge clk) begin
        if (reset) begin
            in_x            = 1'b0;
            avm_waitrequest = 1'b0;
        end else begin
            chk("rd_wr_exclusive", {31'd0, avm_read & avm_write}, 32'd0);
            if (avm_read || avm_write) begin
                if (!in_x) begin
                    s_len  = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                    s_cnt  = 0;
                    in_x   = 1'b1;
                    h_rd   = avm_read;
                    h_addr = avm_address;
                    h_data = avm_writedata;
                end else begin
                    chk("hold_strobe", {31'd0, avm_read}, {31'd0, h_rd});
                    chk("hold_addr", {24'd0, avm_address}, {24'd0, h_addr});
                    if (avm_write) chk("hold_wdata", avm_writedata, h_data);
                end
                if (s_cnt < s_len) begin
                    avm_waitrequest = 1'b1;
                    s_cnt++;
                    avm_readdata = $urandom;
                end else begin
                    avm_waitrequest = 1'b0;
                    in_x = 1'b0;
                    if (avm_read) avm_readdata = (rd_q.size() > 0) ? rd_q.pop_front() : $urandom;
                    if (exp_x.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_xfer: got rd=%0d addr=%h, none expected", avm_read, avm_address);
                    end else begin
                        xfer_t e;
                        e = exp_x.pop_front();
                        chk("xfer_is_read", {31'd0, avm_read}, {31'd0, e.rd});
                        chk("xfer_addr", {24'd0, avm_address}, {24'd0, e.addr});
                        if (!e.rd) chk("xfer_wdata", avm_writedata, e.data);
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                in_x = 1'b0;
                chk("idle_addr", {24'd0, avm_address}, 32'd0);
                chk("idle_wdata", avm_writedata, 32'd0);
            end
            if (rsp_valid) begin
                if (exp_r.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_rsp: got data=%h to=%0d, none expected", rsp_data, rsp_timeout);
                end else begin
                    rsp_t r;
                    r = exp_r.pop_front();
                    chk("rsp_data", rsp_data, r.data);
                    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, r.to});
                    chk("rsp_latency", cyc - r.acc, r.lat);
                    chk("rsp_busy", {31'd0, busy}, 32'd1);
                end
            end
        end
    end

    // Build expectations from the command and stall plan, then present it.
    // Must be called at a negedge with the DUT idle.
    task automatic start_cmd(input logic [31:0] code, input logic [1:0] nargs,
                             input logic [31:0] a [3], input int ls [5],
                             input logic [31:0] rdata, input int extra);
        int    n;
        int    s;
        bit    hit;
        rsp_t  r;
        xfer_t x;
        n   = (int'(nargs) > NA) ? NA : int'(nargs);
        s   = 0;
        hit = 1'b0;
        for (int t = 0; t < n + 2; t++) begin
            if (!hit) begin
                stall_q.push_back(ls[t]);
                if (ls[t] >= TO) begin
                    hit   = 1'b1;
                    r.lat = s + TO + 1;
                end else begin
                    s += ls[t] + 1;
                    if (t < n) begin
                        x.rd = 1'b0; x.addr = 8'(t + 1); x.data = a[t];
                    end else if (t == n) begin
                        x.rd = 1'b0; x.addr = 8'd0; x.data = code;
                    end else begin
                        x.rd = 1'b1; x.addr = SA; x.data = 32'd0;
                    end
                    exp_x.push_back(x);
                end
            end
        end
        if (hit) begin
            r.data = 32'd0;
            r.to   = 1'b1;
        end else begin
            rd_q.push_back(rdata);
            r.data = rdata;
            r.to   = 1'b0;
            r.lat  = s + 1;
        end
        chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        r.acc = cyc;
        exp_r.push_back(r);
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_nargs = nargs;
        cmd_args  = {a[2], a[1], a[0]};
        @(negedge clk);
        // Keep requesting with different contents while busy: must be ignored.
        for (int i = 0; i < extra; i++) begin
            chk("ready_low_busy", {31'd0, cmd_ready}, 32'd0);
            cmd_code = $urandom;
            cmd_args = {$urandom, $urandom, $urandom};
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_r.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_done: response missing after 400 cycles, pending=%0d", exp_r.size());
            exp_r.delete();
        end
        chk("ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("xfers_left", exp_x.size(), 32'd0);
        chk("stalls_left", stall_q.size(), 32'd0);
        exp_x.delete();
        stall_q.delete();
        rd_q.delete();
    endtask

    logic [31:0] a [3];
    int          ls [5];

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_code = 32'd0;
        cmd_nargs = 2'd0;
        cmd_args = '0;
        avm_readdata = 32'd0;
        avm_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
        chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rst_addr", {24'd0, avm_address}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // One argument, no stalls: latency 4, status 0.
        a  = '{32'h3000_0000, 32'd0, 32'd0};
        ls = '{0, 0, 0, 0, 0};
        start_cmd(32'h0000_0001, 2'd1, a, ls, 32'd0, 0);
        wait_done();

        // No arguments, longest stall that does not time out on the status read.
        ls = '{0, TO - 1, 0, 0, 0};
        start_cmd(32'h0000_0002, 2'd0, a, ls, 32'h5, 0);
        wait_done();

        // Three arguments, one stall cycle on the second beat, requests while busy.
        a  = '{32'd11, 32'd22, 32'd33};
        ls = '{0, 1, 0, 0, 0};
        start_cmd(32'h0000_0003, 2'd3, a, ls, 32'hA5A5_0003, 2);
        wait_done();

        // Stuck slave during the command write: timeout, no status read.
        ls = '{TO + 5, 0, 0, 0, 0};
        start_cmd(32'h0000_0004, 2'd0, a, ls, 32'hDEAD_BEEF, 0);
        wait_done();

        // Reset in the middle of the argument phase: no response may follow.
        ls = '{5, 0, 0, 0, 0};
        start_cmd(32'h0000_0005, 2'd3, a, ls, 32'h1234_5678, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        exp_r.delete();
        exp_x.delete();
        stall_q.delete();
        rd_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        a  = '{32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003};
        ls = '{0, 0, 0, 0, 0};
        start_cmd(32'h0000_0006, 2'd2, a, ls, 32'h0000_00C6, 2);
        wait_done();
        repeat (10) @(negedge clk);

        // Randomised commands and stall patterns.
        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < 3; j++) a[j] = $urandom;
            for (int j = 0; j < 5; j++) begin
                int r;
                r = $urandom_range(0, 19);
                ls[j] = (r < 2) ? $urandom_range(TO, TO + 3) :
                        (r < 10) ? 0 : $urandom_range(1, TO - 1);
            end
            start_cmd($urandom, 2'($urandom_range(0, 3)), a, ls, $urandom,
                      $urandom_range(0, 2));
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
